// File: rtl/frame_fifo_write.sv
// Frame writer: cuts one frame of write_len words into SDRAM write bursts of at most
// BURST_SIZE words, launching each burst only once the pixel FIFO holds enough data.
module frame_fifo_write #(
   parameter int MEM_DATA_BITS = 16,
   parameter int ADDR_BITS     = 24,
   parameter int BURST_BITS    = 10,
   parameter int BURST_SIZE    = 128
) (
   input  logic                  mem_clk,
   input  logic                  rst,
   input  logic                  write_req,
   output logic                  write_req_ack,
   output logic                  write_finish,
   input  logic [ADDR_BITS-1:0]  write_addr_0,
   input  logic [ADDR_BITS-1:0]  write_addr_1,
   input  logic [ADDR_BITS-1:0]  write_addr_2,
   input  logic [ADDR_BITS-1:0]  write_addr_3,
   input  logic [1:0]            write_addr_index,
   input  logic [ADDR_BITS-1:0]  write_len,
   output logic                  fifo_aclr,
   input  logic [BURST_BITS-1:0] rd_data_count,
   output logic                  wr_burst_req,
   output logic [BURST_BITS-1:0] wr_burst_len,
   output logic [ADDR_BITS-1:0]  wr_burst_addr,
   input  logic                  wr_burst_data_req,
   input  logic                  wr_burst_data_finish
);

   typedef enum logic [2:0] {
      IDLE,
      ACK,
      CHECK_FIFO,
      WRITE_BURST,
      BURST_END,
      WRITE_END
   } state_t;

   localparam logic [ADDR_BITS-1:0] BURST_SIZE_A = ADDR_BITS'(BURST_SIZE);

   // The largest burst must still be representable on wr_burst_len.
   if (MEM_DATA_BITS < 1 || BURST_SIZE < 1 || BURST_SIZE >= (1 << BURST_BITS)) begin : g_param_check
      $error("frame_fifo_write: BURST_SIZE must lie in 1..2**BURST_BITS-1");
   end

   function automatic logic [ADDR_BITS-1:0] burst_words(input logic [ADDR_BITS-1:0] words_left);
      return (words_left < BURST_SIZE_A) ? words_left : BURST_SIZE_A;
   endfunction

   state_t               state;
   logic                 req_p0;
   logic                 req_s;
   logic [ADDR_BITS-1:0] base;
   logic [ADDR_BITS-1:0] offset;
   logic [ADDR_BITS-1:0] remain;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [ADDR_BITS-1:0] next_len;
   logic [ADDR_BITS-1:0] cur_len;
   logic                 fifo_ready;

   always_comb begin
      sel_addr = write_addr_0;
      case (write_addr_index)
         2'd1:    sel_addr = write_addr_1;
         2'd2:    sel_addr = write_addr_2;
         2'd3:    sel_addr = write_addr_3;
         default: sel_addr = write_addr_0;
      endcase
   end

   assign next_len   = burst_words(remain);
   assign cur_len    = ADDR_BITS'(wr_burst_len);
   assign fifo_ready = ADDR_BITS'(rd_data_count) >= next_len;

   // Stage p0 -> s: two-flop synchroniser for the request, which may come from another domain.
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         req_p0        <= 1'b0;
         req_s         <= 1'b0;
         state         <= IDLE;
         base          <= '0;
         offset        <= '0;
         remain        <= '0;
         write_req_ack <= 1'b0;
         write_finish  <= 1'b0;
         fifo_aclr     <= 1'b0;
         wr_burst_req  <= 1'b0;
         wr_burst_len  <= '0;
         wr_burst_addr <= '0;
      end else begin
         req_p0 <= write_req;
         req_s  <= req_p0;
         case (state)
            IDLE: begin
               if (req_s) begin
                  base          <= sel_addr;
                  remain        <= write_len;
                  offset        <= '0;
                  write_req_ack <= 1'b1;
                  fifo_aclr     <= 1'b1;
                  state         <= ACK;
               end
            end
            ACK: begin
               // The FIFO stays cleared until the requester drops its request.
               if (!req_s) begin
                  write_req_ack <= 1'b0;
                  fifo_aclr     <= 1'b0;
                  if (remain == '0) begin
                     write_finish <= 1'b1;
                     state        <= WRITE_END;
                  end else begin
                     state <= CHECK_FIFO;
                  end
               end
            end
            CHECK_FIFO: begin
               if (fifo_ready) begin
                  wr_burst_len  <= next_len[BURST_BITS-1:0];
                  wr_burst_addr <= base + offset;
                  wr_burst_req  <= 1'b1;
                  state         <= WRITE_BURST;
               end
            end
            WRITE_BURST: begin
               if (wr_burst_data_finish) begin
                  wr_burst_req <= 1'b0;
                  offset       <= offset + cur_len;
                  remain       <= remain - cur_len;
                  state        <= BURST_END;
               end
            end
            BURST_END: begin
               if (remain == '0) begin
                  write_finish <= 1'b1;
                  state        <= WRITE_END;
               end else begin
                  state <= CHECK_FIFO;
               end
            end
            WRITE_END: begin
               write_finish <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // sdram_core only strobes FIFO reads while one of our bursts is outstanding.
   assert property (@(posedge mem_clk) disable iff (rst) wr_burst_data_req |-> state == WRITE_BURST);

endmodule
